// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - display value handshake into the seven-segment scan controller
// The producer drives one complete display value per in_valid/in_ready transfer.
interface seven_seg_scan_ctrl_if #(
  parameter int DIGITS   = 2,
  parameter int PWM_BITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_code;
  logic [DIGITS-1:0]     in_points;
  logic [PWM_BITS-1:0]   brightness;

  modport master (
    output in_valid,
    output in_code,
    output in_points,
    output brightness,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_code,
    input  in_points,
    input  brightness,
    output in_ready
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed seven-segment scan scheduler with blanking and PWM
// New values wait in a shadow buffer and reach the display only at frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int DIGITS        = 2,
  parameter int PRESCALE_BITS = 18,
  parameter int BLANK_CYCLES  = 64,
  parameter int PWM_BITS      = 4
) (
  input  logic                  clk,
  input  logic                  nreset,
  seven_seg_scan_ctrl_if.slave  in_if,
  output logic [DIGITS-1:0]     sel,
  output logic [3:0]            nibble,
  output logic                  point,
  output logic                  seg_en,
  output logic                  frame_start
);

  localparam int DIG_W    = $clog2(DIGITS);
  localparam int SHADOW_W = 4*DIGITS + DIGITS + PWM_BITS;
  localparam logic [PRESCALE_BITS-1:0] BLANK_LAST = PRESCALE_BITS'(BLANK_CYCLES - 1);
  localparam logic [DIG_W-1:0]         LAST_DIGIT = DIG_W'(DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t                   state_q, state_d;
  logic [PRESCALE_BITS-1:0] slot_cnt_q;
  logic [DIG_W-1:0]         digit_q;

  logic [SHADOW_W-1:0]      shadow_q;
  logic                     shadow_full_q;
  logic [4*DIGITS-1:0]      code_act_q;
  logic [DIGITS-1:0]        points_act_q;
  logic [PWM_BITS-1:0]      bright_act_q;

  logic [DIGITS-1:0]        sel_d;
  logic [3:0]               nibble_d;
  logic                     point_d;
  logic                     seg_en_d;

  logic slot_wrap;
  logic frame_end;
  logic xfer;

  assign slot_wrap      = &slot_cnt_q;
  assign frame_end      = slot_wrap && (digit_q == LAST_DIGIT);
  assign xfer           = in_if.in_valid && !shadow_full_q;
  assign in_if.in_ready = ~shadow_full_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_BLANK;
      slot_cnt_q <= '0;
      digit_q    <= '0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_q + 1'b1;
      if (slot_wrap)
        digit_q <= (digit_q == LAST_DIGIT) ? '0 : digit_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (slot_cnt_q == BLANK_LAST) state_d = ST_ON;
      ST_ON:    if (slot_wrap) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // A transfer can only happen while the shadow is empty, so load and store never collide.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      code_act_q    <= '0;
      points_act_q  <= '0;
      bright_act_q  <= '0;
    end else begin
      if (xfer) begin
        shadow_q      <= {in_if.in_code, in_if.in_points, in_if.brightness};
        shadow_full_q <= 1'b1;
      end else if (frame_end && shadow_full_q) begin
        code_act_q    <= shadow_q[SHADOW_W-1 -: 4*DIGITS];
        points_act_q  <= shadow_q[PWM_BITS +: DIGITS];
        bright_act_q  <= shadow_q[PWM_BITS-1:0];
        shadow_full_q <= 1'b0;
      end
    end
  end

  always_comb begin
    sel_d    = '0;
    nibble_d = '0;
    point_d  = 1'b0;
    seg_en_d = 1'b0;
    if (state_q == ST_ON) begin
      sel_d    = DIGITS'(1) << digit_q;
      nibble_d = code_act_q[{digit_q, 2'b00} +: 4];
      point_d  = points_act_q[digit_q];
      seg_en_d = slot_cnt_q[PWM_BITS-1:0] < bright_act_q;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sel         <= '0;
      nibble      <= '0;
      point       <= 1'b0;
      seg_en      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sel         <= sel_d;
      nibble      <= nibble_d;
      point       <= point_d;
      seg_en      <= seg_en_d;
      frame_start <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed bench for seven_seg_scan_ctrl
// DIGITS=2, PRESCALE_BITS=6, BLANK_CYCLES=4, PWM_BITS=2; outputs sampled on the falling edge.
module tb_seven_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       nreset;
  logic [1:0] sel;
  logic [3:0] nibble;
  logic       point;
  logic       seg_en;
  logic       frame_start;

  int total = 0;
  int bad   = 0;

  seven_seg_scan_ctrl_if #(.DIGITS(2), .PWM_BITS(2)) bus ();

  seven_seg_scan_ctrl #(
    .DIGITS(2), .PRESCALE_BITS(6), .BLANK_CYCLES(4), .PWM_BITS(2)
  ) dut (
    .clk(clk), .nreset(nreset), .in_if(bus),
    .sel(sel), .nibble(nibble), .point(point),
    .seg_en(seg_en), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic [1:0] pts;
    logic [1:0] bright;
    logic [3:0] n0;
    logic       p0;
    logic [3:0] n1;
    logic       p1;
    int         cnt;
  } vec_t;

  vec_t vecs[4];

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_frame(input string nm);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (frame_start === 1'b1) begin
        ok = 1;
        break;
      end
    end
    chk({nm, "_fs_seen"}, 32'(ok), 32'd1);
  endtask

  // Starts on a frame_start cycle, ends on the next one; every sample belongs to one frame.
  task automatic observe(input string nm, input logic [3:0] n0, input logic p0,
                         input logic [3:0] n1, input logic p1, input int cnt, input bit chk_rdy);
    int c0 = 0, c1 = 0, cb = 0, e0 = 0, e1 = 0, eb = 0, fs_mid = 0, incon = 0;
    logic [3:0] f_n0 = '0, f_n1 = '0;
    logic f_p0 = 1'b0, f_p1 = 1'b0;
    bit s0 = 0, s1 = 0;
    for (int j = 1; j <= 128; j++) begin
      cyc();
      if (j == 1 && chk_rdy) chk({nm, "_rdy_after_fs"}, 32'(bus.in_ready), 32'd1);
      if (j < 128 && frame_start !== 1'b0) fs_mid++;
      case (sel)
        2'b01: begin
          c0++;
          if (seg_en) e0++;
          if (!s0) begin s0 = 1; f_n0 = nibble; f_p0 = point; end
          else if (nibble !== f_n0 || point !== f_p0) incon++;
        end
        2'b10: begin
          c1++;
          if (seg_en) e1++;
          if (!s1) begin s1 = 1; f_n1 = nibble; f_p1 = point; end
          else if (nibble !== f_n1 || point !== f_p1) incon++;
        end
        2'b00: begin
          cb++;
          if (seg_en !== 1'b0) eb++;
        end
        default: incon++;
      endcase
    end
    chk({nm, "_on0"}, 32'(c0), 32'd60);
    chk({nm, "_on1"}, 32'(c1), 32'd60);
    chk({nm, "_blank"}, 32'(cb), 32'd8);
    chk({nm, "_nib0"}, 32'(f_n0), 32'(n0));
    chk({nm, "_pt0"}, 32'(f_p0), 32'(p0));
    chk({nm, "_nib1"}, 32'(f_n1), 32'(n1));
    chk({nm, "_pt1"}, 32'(f_p1), 32'(p1));
    chk({nm, "_duty0"}, 32'(e0), 32'(cnt));
    chk({nm, "_duty1"}, 32'(e1), 32'(cnt));
    chk({nm, "_blank_dark"}, 32'(eb), 32'd0);
    chk({nm, "_stable"}, 32'(incon), 32'd0);
    chk({nm, "_fs_mid"}, 32'(fs_mid), 32'd0);
    chk({nm, "_fs_end"}, 32'(frame_start), 32'd1);
  endtask

  task automatic put(input logic [7:0] c, input logic [1:0] p, input logic [1:0] b);
    bus.in_valid   = 1'b1;
    bus.in_code    = c;
    bus.in_points  = p;
    bus.brightness = b;
  endtask

  initial begin
    int first;
    int gap;

    vecs[0] = '{8'hA5, 2'b10, 2'd3, 4'h5, 1'b0, 4'hA, 1'b1, 45};
    vecs[1] = '{8'h12, 2'b01, 2'd0, 4'h2, 1'b1, 4'h1, 1'b0, 0};
    vecs[2] = '{8'hF0, 2'b11, 2'd1, 4'h0, 1'b1, 4'hF, 1'b1, 15};
    vecs[3] = '{8'h7E, 2'b00, 2'd2, 4'hE, 1'b0, 4'h7, 1'b0, 30};

    bus.in_valid = 1'b0; bus.in_code = '0; bus.in_points = '0; bus.brightness = '0;
    nreset = 1'b0;
    repeat (3) cyc();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_seg_en", 32'(seg_en), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_nibble", 32'(nibble), 32'd0);

    nreset = 1'b1;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (sel !== 2'b00) begin first = k; break; end
    end
    chk("first_sel_delay", 32'(first), 32'd5);
    chk("first_sel_val", 32'(sel), 32'b01);
    chk("first_dark", 32'(seg_en), 32'd0);
    gap = 0;
    for (int m = 1; m <= 200; m++) begin
      cyc();
      if (sel === 2'b10) begin gap = m; break; end
    end
    chk("sel10_gap", 32'(gap), 32'd64);

    foreach (vecs[v]) begin
      chk($sformatf("v%0d_ready_pre", v), 32'(bus.in_ready), 32'd1);
      put(vecs[v].code, vecs[v].pts, vecs[v].bright);
      cyc();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_ready_post", v), 32'(bus.in_ready), 32'd0);
      wait_frame($sformatf("v%0d", v));
      observe($sformatf("v%0d", v), vecs[v].n0, vecs[v].p0, vecs[v].n1, vecs[v].p1,
              vecs[v].cnt, 1'b0);
    end

    put(8'h11, 2'b01, 2'd2);
    cyc();
    chk("b2b_ready_after_first", 32'(bus.in_ready), 32'd0);
    put(8'h99, 2'b10, 2'd3);
    repeat (10) cyc();
    chk("b2b_ready_held", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    wait_frame("b2b");
    observe("b2b_f1", 4'h1, 1'b1, 4'h1, 1'b0, 30, 1'b1);
    observe("b2b_f2", 4'h1, 1'b1, 4'h1, 1'b0, 30, 1'b1);

    repeat (127) cyc();
    put(8'h3C, 2'b00, 2'd3);
    cyc();
    bus.in_valid = 1'b0;
    chk("bnd_fs", 32'(frame_start), 32'd1);
    chk("bnd_ready", 32'(bus.in_ready), 32'd0);
    observe("bnd_old", 4'h1, 1'b1, 4'h1, 1'b0, 30, 1'b0);
    observe("bnd_new", 4'hC, 1'b0, 4'h3, 1'b0, 45, 1'b1);

    put(8'h77, 2'b11, 2'd3);
    cyc();
    bus.in_valid = 1'b0;
    repeat (83) cyc();
    chk("mid_sel", 32'(sel), 32'b10);
    chk("mid_ready", 32'(bus.in_ready), 32'd0);
    nreset = 1'b0;
    #1;
    chk("async_sel", 32'(sel), 32'd0);
    chk("async_seg_en", 32'(seg_en), 32'd0);
    chk("async_nibble", 32'(nibble), 32'd0);
    chk("async_point", 32'(point), 32'd0);
    chk("async_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    nreset = 1'b1;
    wait_frame("post_rst");
    observe("post_rst_f1", 4'h0, 1'b0, 4'h0, 1'b0, 0, 1'b1);
    observe("post_rst_f2", 4'h0, 1'b0, 4'h0, 1'b0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
